// File: rtl/div_seq.sv
// div_seq: multicycle signed 32-bit divider (MIPS div rs, rt).
// Restoring division on operand magnitudes, 32 step cycles plus one sign-fix
// cycle. Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   DivStart  start request, sampled only in IDLE
//   Dividend  signed dividend, sampled on the accepting edge
//   Divisor   signed divisor, sampled on the accepting edge
//   DivHi     remainder (registered)
//   DivLo     quotient (registered)
//   DivDone   one-cycle pulse, DivHi/DivLo newly updated
//   DivZero   one-cycle pulse, divisor was zero, no result produced
//   DivBusy   high while RUN or FIX is in progress
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        DivStart,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic [31:0] DivHi,
    output logic [31:0] DivLo,
    output logic        DivDone,
    output logic        DivZero,
    output logic        DivBusy
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state, w_state;
    // Partial remainder: its top bit is always zero after a restoring step,
    // so only the low W bits are kept; the trial subtraction supplies bit W.
    logic [W-1:0]    r_rem,   w_rem;
    logic [W-1:0]    r_quo,   w_quo;
    logic [W-1:0]    r_dsr,   w_dsr;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic            r_sign_q, w_sign_q;
    logic            r_sign_r, w_sign_r;
    logic [W-1:0]    r_hi,    w_hi;
    logic [W-1:0]    r_lo,    w_lo;
    logic            r_done,  w_done;
    logic            r_zero,  w_zero;
    logic            r_busy,  w_busy;

    logic [W-1:0]    w_dvd_mag;
    logic [W-1:0]    w_dsr_mag;
    logic [W:0]      w_trial;

    // Two's-complement magnitudes; 0x80000000 maps to unsigned 2^31 exactly.
    assign w_dvd_mag = Dividend[W-1] ? W'(-Dividend) : Dividend;
    assign w_dsr_mag = Divisor[W-1]  ? W'(-Divisor)  : Divisor;

    // Trial subtraction of the shifted remainder; bit W set means "restore".
    assign w_trial = {r_rem, r_quo[W-1]} - {1'b0, r_dsr};

    // Next-state and datapath update.
    always_comb begin
        w_state  = r_state;
        w_rem    = r_rem;
        w_quo    = r_quo;
        w_dsr    = r_dsr;
        w_cnt    = r_cnt;
        w_sign_q = r_sign_q;
        w_sign_r = r_sign_r;
        w_hi     = r_hi;
        w_lo     = r_lo;
        w_done   = 1'b0;
        w_zero   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (DivStart) begin
                    if (Divisor == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_dsr    = w_dsr_mag;
                        w_sign_q = Dividend[W-1] ^ Divisor[W-1];
                        w_sign_r = Dividend[W-1];
                        w_rem    = '0;
                        w_quo    = w_dvd_mag;
                        w_cnt    = CW'(W - 1);
                        w_state  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!w_trial[W]) begin
                    w_rem = w_trial[W-1:0];
                    w_quo = {r_quo[W-2:0], 1'b1};
                end else begin
                    w_rem = {r_rem[W-2:0], r_quo[W-1]};
                    w_quo = {r_quo[W-2:0], 1'b0};
                end
                w_cnt = r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    w_state = S_FIX;
                end
            end
            S_FIX: begin
                w_lo    = r_sign_q ? W'(-r_quo) : r_quo;
                w_hi    = r_sign_r ? W'(-r_rem) : r_rem;
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rem    <= w_rem;
            r_quo    <= w_quo;
            r_dsr    <= w_dsr;
            r_cnt    <= w_cnt;
            r_sign_q <= w_sign_q;
            r_sign_r <= w_sign_r;
            r_hi     <= w_hi;
            r_lo     <= w_lo;
            r_done   <= w_done;
            r_zero   <= w_zero;
            r_busy   <= w_busy;
        end
    end

    assign DivHi   = r_hi;
    assign DivLo   = r_lo;
    assign DivDone = r_done;
    assign DivZero = r_zero;
    assign DivBusy = r_busy;

endmodule

// File: doc/div_seq.md
# div_seq

Multicycle signed 32-bit divider for the multicycle MIPS datapath. It implements `div rs, rt`. The control unit launches it with the A and B register outputs as operands. The block produces quotient (LO) and remainder (HI), which feed the HI/LO selection muxes ahead of the HI and LO registers. It also raises the divide-by-zero flag that the control unit uses to enter the exception sequence.

## Interface
Parameters:
- None. Width is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
- DivStart  in  1  start request; sampled only in IDLE.
- Dividend  in  32  signed dividend (A register output); sampled on the accepting edge only.
- Divisor  in  32  signed divisor (B register output); sampled on the accepting edge only.
- DivHi  out  32  remainder; registered, feeds the HI-select mux.
- DivLo  out  32  quotient; registered, feeds the LO-select mux.
- DivDone  out  1  one-cycle pulse; DivHi/DivLo are valid and newly updated.
- DivZero  out  1  one-cycle pulse; divisor was zero and no result was produced.
- DivBusy  out  1  high while an operation is in progress (RUN or FIX).

## Operation
States and transitions:
- IDLE
  - DivStart=1 and Divisor=0: stay IDLE. DivZero=1 next cycle. DivHi/DivLo unchanged.
  - DivStart=1 and Divisor≠0:
    - latch |Dividend| and |Divisor| as 32-bit unsigned magnitudes;
    - latch sign_q = Dividend[31]^Divisor[31] and sign_r = Dividend[31];
    - clear the 33-bit partial remainder R and the quotient shift register Q;
    - load Q with |Dividend| and set the counter to 31;
    - go to RUN.
- RUN (32 cycles), restoring step each edge:
  - compute T = {R[31:0], Q[31]} − {1'b0, |Divisor|} in 33 bits;
  - if T[32]=0: R←T and Q←{Q[30:0],1};
  - else: R←{R[31:0],Q[31]} and Q←{Q[30:0],0};
  - decrement the counter;
  - when counter=0 on a step edge, go to FIX.
- FIX (1 cycle):
  - DivLo ← sign_q ? −Q : Q;
  - DivHi ← sign_r ? −R[31:0] : R[31:0];
  - DivDone=1 next cycle;
  - go to IDLE.

Arithmetic rules:
- Quotient truncates toward zero. The remainder takes the sign of the dividend, matching MIPS `div`.
- |x| is computed in two's complement. |0x80000000| = 0x80000000 is treated as unsigned 2^31, so it is exact.
- Overflow case 0x80000000 / 0xFFFFFFFF gives DivLo=0x80000000 and DivHi=0. No flag is raised.

Boundary conditions:
- DivStart while DivBusy=1 is ignored. Operand changes during RUN have no effect.
- DivStart in the cycle where DivDone=1 (state already IDLE) is accepted.
- DivZero and DivDone are never high in the same cycle.
- A zero-divisor request does not disturb a previously held result.
- reset at any point, including mid-RUN or FIX, has the same effect:
  - next state IDLE;
  - DivHi=0, DivLo=0;
  - DivDone=0, DivZero=0, DivBusy=0;
  - R, Q and counter cleared;
  - no DivDone is produced for the aborted operation.
- DivHi/DivLo hold their value in every state except the FIX edge and reset.

## Timing
- Reset values: DivHi=0, DivLo=0, DivDone=0, DivZero=0, DivBusy=0, state IDLE.
- Accepting edge E0 is the edge where DivStart is sampled high in IDLE.
- Normal operation:
  - DivBusy=1 from after E0 until after E33;
  - RUN steps occur on edges E1–E32;
  - the FIX edge is E33;
  - DivDone=1 during the cycle following E33, with the result stable from that cycle onward;
  - total latency is 33 cycles from the accepting edge to DivDone.
- Zero divisor: DivZero=1 during the cycle following E0. DivBusy stays 0.
- Pulses (DivDone, DivZero) are exactly one cycle wide and registered, not combinational from inputs.
- Maximum throughput is one division per 34 cycles (start accepted in the DivDone cycle).

## Test plan
- Positive operands: 7 / 2 → DivDone exactly 33 cycles after the start edge; DivLo=3, DivHi=1; DivBusy low afterwards.
- Sign combinations:
  - −7 / 2 → DivLo=0xFFFFFFFD, DivHi=0xFFFFFFFF;
  - 7 / −2 → DivLo=0xFFFFFFFD, DivHi=1;
  - −7 / −2 → DivLo=3, DivHi=0xFFFFFFFF.
- Extremes:
  - 0x80000000 / 0xFFFFFFFF → DivLo=0x80000000, DivHi=0;
  - 0xFFFFFFFF / 0x7FFFFFFF → DivLo=0, DivHi=0xFFFFFFFF;
  - 0 / 5 → 0, 0.
- Divide by zero: load result 7/2, then start 9 / 0 → DivZero=1 for one cycle after the start edge; DivDone never asserts; DivHi=1 and DivLo=3 retained.
- Start while busy: start 100 / 7, pulse DivStart with 1 / 1 at cycle 10 → ignored; DivLo=14, DivHi=2 at cycle 33.
- Reset mid-op:
  - start 100 / 7 and assert reset at cycle 15 → all outputs 0 next cycle, no DivDone;
  - then start 50 / 3 → DivLo=16, DivHi=2 after 33 cycles.
